// File: rtl/cpu_run_ctrl.sv
// Run/stop arbiter for the 65C02 phaser: debugger halt, N-cycle step,
// and DMA bus takeover once the CPU clock is confirmed parked.
module cpu_run_ctrl #(
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_stop_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_cnt,
    input  logic              dma_req,
    input  logic              stopped,
    input  logic              release_cs,
    output logic              run,
    output logic              dma_gnt,
    output logic              step_done,
    output logic              halted,
    output logic [STEP_W-1:0] steps_left
);

    typedef enum logic [2:0] {
        S_RUN,
        S_STOPPING,
        S_HALTED,
        S_STEPPING,
        S_DMA
    } state_t;

    state_t            state, state_n;
    logic [STEP_W-1:0] cnt_n;
    logic              step_flag, step_flag_n;
    logic              step_done_n;

    always_comb begin
        state_n     = state;
        cnt_n       = steps_left;
        step_flag_n = step_flag;
        step_done_n = 1'b0;
        unique case (state)
            S_RUN: begin
                if (dma_req || cpu_stop_req)
                    state_n = S_STOPPING;
            end
            S_STOPPING: begin
                if (stopped) begin
                    state_n = dma_req ? S_DMA : S_HALTED;
                    if (step_flag) begin
                        step_done_n = 1'b1;
                        step_flag_n = 1'b0;
                    end
                end
            end
            S_HALTED: begin
                if (dma_req) begin
                    state_n = S_DMA;
                end else if (step_req && step_cnt != '0) begin
                    state_n     = S_STEPPING;
                    cnt_n       = step_cnt;
                    step_flag_n = 1'b1;
                end else if (step_req) begin
                    step_done_n = 1'b1;
                end else if (!cpu_stop_req) begin
                    state_n = S_RUN;
                end
            end
            // Step is atomic: only release_cs is honoured here.
            S_STEPPING: begin
                if (release_cs) begin
                    cnt_n = steps_left - STEP_W'(1);
                    if (steps_left == STEP_W'(1))
                        state_n = S_STOPPING;
                end
            end
            S_DMA: begin
                if (!dma_req)
                    state_n = S_HALTED;
            end
            default: state_n = S_HALTED;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_HALTED;
            step_flag  <= 1'b0;
            run        <= 1'b0;
            dma_gnt    <= 1'b0;
            step_done  <= 1'b0;
            halted     <= 1'b1;
            steps_left <= '0;
        end else begin
            state      <= state_n;
            step_flag  <= step_flag_n;
            run        <= (state_n == S_RUN) ||
                          (state_n == S_STEPPING);
            dma_gnt    <= (state_n == S_DMA);
            step_done  <= step_done_n;
            halted     <= (state_n == S_HALTED);
            steps_left <= cnt_n;
        end
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed vector bench for cpu_run_ctrl; phaser stopped/release_cs
// are driven straight from the vectors.
module tb_cpu_run_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       cpu_stop_req, step_req, dma_req;
    logic       stopped, release_cs;
    logic [7:0] step_cnt;
    logic       run, dma_gnt, step_done, halted;
    logic [7:0] steps_left;

    int nvec = 0;
    int nfail = 0;

    always #10 clk = ~clk;

    cpu_run_ctrl #(.STEP_W(8)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .cpu_stop_req (cpu_stop_req),
        .step_req     (step_req),
        .step_cnt     (step_cnt),
        .dma_req      (dma_req),
        .stopped      (stopped),
        .release_cs   (release_cs),
        .run          (run),
        .dma_gnt      (dma_gnt),
        .step_done    (step_done),
        .halted       (halted),
        .steps_left   (steps_left)
    );

    typedef struct {
        string      name;
        logic       stop;
        logic       step;
        logic [7:0] cnt;
        logic       dma;
        logic       stp;
        logic       rel;
        logic       run;
        logic       gnt;
        logic       done;
        logic       hlt;
        logic [7:0] left;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        string n,
        logic stop, logic step, logic [7:0] cnt,
        logic dma, logic stp, logic rel,
        logic r, logic g, logic d, logic h,
        logic [7:0] l);
        vec_t v;
        v.name = n;    v.stop = stop; v.step = step;
        v.cnt  = cnt;  v.dma  = dma;  v.stp  = stp;
        v.rel  = rel;  v.run  = r;    v.gnt  = g;
        v.done = d;    v.hlt  = h;    v.left = l;
        return v;
    endfunction

    task automatic check(input vec_t v);
        nvec++;
        if (run !== v.run || dma_gnt !== v.gnt ||
            step_done !== v.done || halted !== v.hlt ||
            steps_left !== v.left || (run && dma_gnt)) begin
            nfail++;
            $display("FAIL %s: got run=%b gnt=%b done=%b hlt=%b left=%0d, want run=%b gnt=%b done=%b hlt=%b left=%0d",
                v.name, run, dma_gnt, step_done, halted,
                steps_left, v.run, v.gnt, v.done, v.hlt, v.left);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        cpu_stop_req = v.stop;
        step_req     = v.step;
        step_cnt     = v.cnt;
        dma_req      = v.dma;
        stopped      = v.stp;
        release_cs   = v.rel;
        @(posedge clk);
        #1;
        check(v);
    endtask

    initial begin
        resetn = 1'b0;
        cpu_stop_req = 0; step_req = 0; step_cnt = 0;
        dma_req = 0; stopped = 1; release_cs = 0;

        //            name        stp stq cnt dma sd rel  run gnt dn hl left
        tbl.push_back(mk("boot",   0,0,0, 0,1,0, 1,0,0,0,0));
        tbl.push_back(mk("run",    0,0,0, 0,0,0, 1,0,0,0,0));
        tbl.push_back(mk("stop0",  1,0,0, 0,0,0, 0,0,0,0,0));
        tbl.push_back(mk("stop1",  1,0,0, 0,0,0, 0,0,0,0,0));
        tbl.push_back(mk("halt",   1,0,0, 0,1,0, 0,0,0,1,0));
        tbl.push_back(mk("hold",   1,0,0, 0,1,0, 0,0,0,1,0));
        tbl.push_back(mk("resume", 0,0,0, 0,1,0, 1,0,0,0,0));
        tbl.push_back(mk("stop2",  1,0,0, 0,0,0, 0,0,0,0,0));
        tbl.push_back(mk("halt2",  1,0,0, 0,1,0, 0,0,0,1,0));
        tbl.push_back(mk("st3",    1,1,3, 0,1,0, 1,0,0,0,3));
        tbl.push_back(mk("st3w",   1,0,0, 0,0,0, 1,0,0,0,3));
        tbl.push_back(mk("st3r1",  1,0,0, 0,0,1, 1,0,0,0,2));
        tbl.push_back(mk("st3w2",  1,0,0, 0,0,0, 1,0,0,0,2));
        tbl.push_back(mk("st3r2",  1,0,0, 0,0,1, 1,0,0,0,1));
        tbl.push_back(mk("st3r3",  1,0,0, 0,0,1, 0,0,0,0,0));
        tbl.push_back(mk("st3spin",1,0,0, 0,0,0, 0,0,0,0,0));
        tbl.push_back(mk("st3done",1,0,0, 0,1,0, 0,0,1,1,0));
        tbl.push_back(mk("st3idle",1,0,0, 0,1,0, 0,0,0,1,0));
        tbl.push_back(mk("st0",    1,1,0, 0,1,0, 0,0,1,1,0));
        tbl.push_back(mk("st0idle",1,0,0, 0,1,0, 0,0,0,1,0));
        tbl.push_back(mk("relign", 1,0,0, 0,1,1, 0,0,0,1,0));
        tbl.push_back(mk("dmastep",1,1,4, 1,1,0, 0,1,0,0,0));
        tbl.push_back(mk("dmahold",1,0,0, 1,1,0, 0,1,0,0,0));
        tbl.push_back(mk("dmaoff", 0,0,0, 0,1,0, 0,0,0,1,0));
        tbl.push_back(mk("dmarun", 0,0,0, 0,1,0, 1,0,0,0,0));
        tbl.push_back(mk("rdma0",  0,0,0, 1,0,0, 0,0,0,0,0));
        tbl.push_back(mk("rdma1",  0,0,0, 1,0,0, 0,0,0,0,0));
        tbl.push_back(mk("rdmagnt",0,0,0, 1,1,0, 0,1,0,0,0));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk("rdmahld",0,0,0, 1,1,0, 0,1,0,0,0));
        tbl.push_back(mk("rdmaoff",0,0,0, 0,1,0, 0,0,0,1,0));
        tbl.push_back(mk("rdmarun",0,0,0, 0,0,0, 1,0,0,0,0));

        repeat (3) @(posedge clk);
        #1;
        check(mk("reset", 0,0,0, 0,1,0, 0,0,0,1,0));
        @(negedge clk);
        resetn = 1'b1;

        foreach (tbl[i])
            apply(tbl[i]);

        // Step of 5 with DMA raised mid-step: all 5 cycles must run.
        apply(mk("s5stop", 1,0,0, 0,0,0, 0,0,0,0,0));
        apply(mk("s5halt", 1,0,0, 0,1,0, 0,0,0,1,0));
        apply(mk("s5go",   0,1,5, 0,1,0, 1,0,0,0,5));
        apply(mk("s5r1",   0,0,0, 0,0,1, 1,0,0,0,4));
        apply(mk("s5r2",   0,0,0, 0,0,1, 1,0,0,0,3));
        apply(mk("s5dma",  0,0,0, 1,0,0, 1,0,0,0,3));
        apply(mk("s5r3",   0,0,0, 1,0,1, 1,0,0,0,2));
        apply(mk("s5r4",   0,0,0, 1,0,1, 1,0,0,0,1));
        apply(mk("s5r5",   0,0,0, 1,0,1, 0,0,0,0,0));
        apply(mk("s5gnt",  0,0,0, 1,1,0, 0,1,1,0,0));
        apply(mk("s5hold", 0,0,0, 1,1,0, 0,1,0,0,0));

        // Asynchronous reset in the middle of DMA.
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check(mk("asyncrst", 0,0,0, 1,1,0, 0,0,0,1,0));
        @(negedge clk);
        resetn = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==",
            nvec, nfail);
        $finish;
    end

endmodule
